// File: rtl/draw_title.sv
// draw_title: title ROM addressing plus keyed, alpha-blended compositing over background video.
// Define TITLE_FADE_EN for the frame-stepped fade FSM; otherwise the title switches on/off instantly.
module draw_title #(
  parameter int unsigned XPOS        = 112,
  parameter int unsigned YPOS        = 50,
  parameter int unsigned WIDTH       = 800,
  parameter int unsigned HEIGHT      = 131,
  parameter int unsigned ROM_LAT     = 1,
  parameter logic [23:0] KEY_COLOR   = 24'h00FF00,
  parameter int unsigned FADE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [23:0] rgb_in,
  input  logic [23:0] rom_pixel,
  output logic [19:0] rom_addr,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [23:0] rgb_out,
  output logic        title_on
);
  localparam int unsigned PW = 51;
  typedef enum logic [1:0] {OFF, FADE_IN, ON, FADE_OUT} state_t;
  state_t state, state_nxt;
  logic [4:0] alpha, alpha_nxt;
  logic in_rect;
  logic [PW-1:0] pipe_a;
  logic [PW-1:0] pipe_d [ROM_LAT];
  logic d_rect, d_hs, d_vs, d_hb, d_vb;
  logic [23:0] d_rgb, mix, rgb_sel;
  logic [10:0] d_hc, d_vc;
  always_comb
    in_rect = 32'(hcount_in) >= XPOS && 32'(hcount_in) < XPOS + WIDTH &&
              32'(vcount_in) >= YPOS && 32'(vcount_in) < YPOS + HEIGHT;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rom_addr <= '0;
      pipe_a <= '0;
    end else begin
      rom_addr <= in_rect ? 20'((32'(vcount_in) - YPOS) * WIDTH + 32'(hcount_in) - XPOS) : '0;
      pipe_a <= {in_rect, rgb_in, hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
    end
  // Hold timing and background for the ROM read so they line up with rom_pixel.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < ROM_LAT; i++) pipe_d[i] <= '0;
    end else begin
      pipe_d[0] <= pipe_a;
      for (int i = 1; i < ROM_LAT; i++) pipe_d[i] <= pipe_d[i-1];
    end
  always_comb {d_rect, d_rgb, d_hc, d_vc, d_hs, d_vs, d_hb, d_vb} = pipe_d[ROM_LAT-1];
  function automatic logic [7:0] blend(input logic [7:0] f, input logic [7:0] b, input logic [4:0] a);
    logic [12:0] s;
    s = 13'(f) * 13'(a) + 13'(b) * (13'd16 - 13'(a));
    return s[11:4];
  endfunction
  always_comb begin
    mix = {blend(rom_pixel[23:16], d_rgb[23:16], alpha),
           blend(rom_pixel[15:8], d_rgb[15:8], alpha),
           blend(rom_pixel[7:0], d_rgb[7:0], alpha)};
    rgb_sel = (d_hb || d_vb) ? 24'h0 :
              (!d_rect || rom_pixel == KEY_COLOR || alpha == 5'd0) ? d_rgb : mix;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} <= '0;
      rgb_out <= '0;
    end else begin
      {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} <= {d_hc, d_vc, d_hs, d_vs, d_hb, d_vb};
      rgb_out <= rgb_sel;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= OFF;
      alpha <= '0;
    end else begin
      state <= state_nxt;
      alpha <= alpha_nxt;
    end
`ifdef TITLE_FADE_EN
  localparam int unsigned FW = FADE_FRAMES > 1 ? $clog2(FADE_FRAMES) : 1;
  logic vs_q, tick, step;
  logic [FW-1:0] fcnt;
  always_comb begin
    tick = vsync_in && !vs_q;
    step = tick && 32'(fcnt) == FADE_FRAMES - 1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      vs_q <= 1'b0;
      fcnt <= '0;
    end else begin
      vs_q <= vsync_in;
      fcnt <= (state_nxt != state || step) ? '0 : tick ? fcnt + 1'b1 : fcnt;
    end
  // An enable change outranks a step landing on the same cycle, keeping alpha within 0..16.
  always_comb begin
    state_nxt = state;
    alpha_nxt = alpha;
    case (state)
      OFF: begin
        alpha_nxt = 5'd0;
        if (enable) state_nxt = FADE_IN;
      end
      FADE_IN:
        if (!enable) state_nxt = FADE_OUT;
        else if (alpha >= 5'd16) state_nxt = ON;
        else if (step) begin
          alpha_nxt = alpha + 5'd1;
          if (alpha == 5'd15) state_nxt = ON;
        end
      ON: begin
        alpha_nxt = 5'd16;
        if (!enable) state_nxt = FADE_OUT;
      end
      FADE_OUT:
        if (enable) state_nxt = FADE_IN;
        else if (alpha == 5'd0) state_nxt = OFF;
        else if (step) begin
          alpha_nxt = alpha - 5'd1;
          if (alpha == 5'd1) state_nxt = OFF;
        end
    endcase
  end
`else
  always_comb begin
    state_nxt = enable ? ON : OFF;
    alpha_nxt = enable ? 5'd16 : 5'd0;
  end
`endif
  always_comb title_on = state == ON;
endmodule

// File: tb/tb_draw_title.sv
// tb_draw_title: randomized frames against a frame-level fade model, checked through a scoreboard.
`timescale 1ns/1ps
module tb_draw_title;
  localparam int XPOS = 112, YPOS = 50, WIDTH = 800, HEIGHT = 131, FF = 2;
  localparam logic [23:0] KEY = 24'h00FF00;
  logic clk = 0, rst = 0, enable = 0;
  logic [10:0] hcount_in = 0, vcount_in = 0, hcount_out, vcount_out;
  logic hsync_in = 0, vsync_in = 0, hblnk_in = 0, vblnk_in = 0;
  logic hsync_out, vsync_out, hblnk_out, vblnk_out, title_on;
  logic [23:0] rgb_in = 0, rom_pixel = 0, rgb_out;
  logic [19:0] rom_addr;
  logic [23:0] rom_mem [64];
  typedef struct {int due; logic [19:0] addr; logic [10:0] hc, vc; logic [3:0] sync; logic [23:0] rgb; logic chk_on, on;} exp_t;
  exp_t qa[$], qo[$], ea, eo;
  int cyc = 0, checks = 0, errors = 0;
  int alpha = 0, n = 0;
  logic en_m = 0, vs_m = 0;
  int hedge[4] = '{XPOS - 1, XPOS, XPOS + WIDTH - 1, XPOS + WIDTH};
  int vedge[4] = '{YPOS - 1, YPOS, YPOS + HEIGHT - 1, YPOS + HEIGHT};

  draw_title dut (.clk(clk), .rst(rst), .enable(enable), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .rom_pixel(rom_pixel), .rom_addr(rom_addr), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .title_on(title_on));

  always #5 clk = ~clk;
  always @(posedge clk) rom_pixel <= rom_mem[rom_addr[5:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  function automatic bit in_rect(int h, int v);
    return h >= XPOS && h < XPOS + WIDTH && v >= YPOS && v < YPOS + HEIGHT;
  endfunction
  function automatic int exp_addr(int h, int v);
    return in_rect(h, v) ? (v - YPOS) * WIDTH + (h - XPOS) : 0;
  endfunction
  function automatic logic [23:0] exp_rgb(int h, int v, logic hb, logic vb, logic [23:0] bg);
    logic [23:0] f, r;
    if (hb || vb) return 24'h0;
    if (!in_rect(h, v)) return bg;
    f = rom_mem[exp_addr(h, v) % 64];
    if (f == KEY || alpha == 0) return bg;
    for (int k = 0; k < 3; k++) r[8*k +: 8] = 8'((f[8*k +: 8] * alpha + bg[8*k +: 8] * (16 - alpha)) / 16);
    return r;
  endfunction

  // Monitor: compare whatever is due once outputs have settled after the edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    while (qa.size() > 0 && qa[0].due <= cyc) begin
      ea = qa.pop_front();
      chk("rom_addr", 32'(rom_addr), 32'(ea.addr));
    end
    while (qo.size() > 0 && qo[0].due <= cyc) begin
      eo = qo.pop_front();
      chk("hcount_out", 32'(hcount_out), 32'(eo.hc));
      chk("vcount_out", 32'(vcount_out), 32'(eo.vc));
      chk("sync_blank", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'(eo.sync));
      chk("rgb_out", 32'(rgb_out), 32'(eo.rgb));
      if (eo.chk_on) chk("title_on", 32'(title_on), 32'(eo.on));
    end
  end

  task automatic drive(input logic en, input int h, input int v, input logic hs, input logic vs,
                       input logic hb, input logic vb, input logic [23:0] bg);
    exp_t e;
    @(negedge clk);
    enable = en;
    hcount_in = 11'(h); vcount_in = 11'(v);
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = bg;
    if (en !== en_m) begin
      en_m = en;
      n = 0;
`ifndef TITLE_FADE_EN
      alpha = en ? 16 : 0;
`endif
    end else if (vs && !vs_m) begin
      n++;
`ifdef TITLE_FADE_EN
      if (n % FF == 0) alpha = en_m ? (alpha < 16 ? alpha + 1 : 16) : (alpha > 0 ? alpha - 1 : 0);
`endif
    end
    vs_m = vs;
    e.due = cyc + 1;
    e.addr = 20'(exp_addr(h, v));
    qa.push_back(e);
    e.due = cyc + 3;
    e.hc = 11'(h); e.vc = 11'(v); e.sync = {hs, vs, hb, vb};
    e.rgb = exp_rgb(h, v, hb, vb, bg);
    e.chk_on = !vb;
    e.on = en_m && alpha == 16;
    qo.push_back(e);
  endtask

  // Enable and vsync only move inside vblank so alpha is steady across the visible pixels.
  task automatic frame(input logic en, input int en_at, input int npix);
    int h, v, m;
    for (int c = 0; c < 10; c++)
      drive(c == en_at ? en : enable, $urandom_range(2047), $urandom_range(2047), 1'b0, c >= 5 && c <= 7, 1'b1, 1'b1, 24'($urandom));
    drive(enable, 200, 60, 1'b0, 1'b0, 1'b0, 1'b0, 24'h123456);
    drive(enable, 113, 60, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0000FF);
    drive(enable, 50, 60, 1'b0, 1'b0, 1'b0, 1'b0, 24'($urandom));
    drive(enable, 300, 100, 1'b0, 1'b0, 1'b1, 1'b0, 24'($urandom));
    for (int p = 0; p < npix; p++) begin
      m = $urandom_range(7);
      h = m < 2 ? hedge[$urandom_range(3)] : m == 2 ? $urandom_range(2047) : $urandom_range(XPOS + WIDTH + 1, XPOS - 2);
      v = m < 2 ? vedge[$urandom_range(3)] : m == 2 ? $urandom_range(2047) : $urandom_range(YPOS + HEIGHT + 1, YPOS - 2);
      drive(enable, h, v, 1'($urandom), 1'b0, $urandom_range(7) == 0, 1'b0, 24'($urandom));
    end
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_counts"}, 32'({hcount_out, vcount_out}), 0);
    chk({tag, "_sync_blank"}, 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 0);
    chk({tag, "_rgb_out"}, 32'(rgb_out), 0);
    chk({tag, "_title_on"}, 32'(title_on), 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      rom_mem[i] = i % 4 == 0 ? KEY : i % 4 == 1 ? 24'hFF0000 : 24'($urandom);
    repeat (3) @(negedge clk);
    reset_check("reset");
    rst = 1;
    for (int f = 0; f < 10; f++) frame(1'b1, 3, 16);
    for (int f = 0; f < 12; f++) frame(1'b0, 3, 16);
    for (int f = 0; f < 40; f++) frame(1'b1, 3, 16);
    for (int f = 0; f < 25; f++) frame(1'($urandom), $urandom_range(1) ? 5 : 3, 16);
    @(negedge clk);
    hblnk_in = 0; vblnk_in = 0; hcount_in = 400; vcount_in = 90;
    #2 rst = 0;
    #1 reset_check("midreset");
    qa.delete(); qo.delete();
    enable = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    alpha = 0; n = 0; en_m = 0; vs_m = 0;
    for (int f = 0; f < 4; f++) frame(1'b1, 3, 16);
    repeat (5) @(negedge clk);
    chk("scoreboard_drain", 32'(qa.size() + qo.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/draw_title.md
Name: draw_title

Overview:
- Drawing stage directly upstream of the title-screen ROM in the VGA pixel chain.
- Takes VGA timing and background RGB, computes the ROM address for the title rectangle, and delays timing by the ROM read latency.
- Blends the returned 24-bit ROM pixel over the background, with keyed transparency and a frame-stepped fade in/out controlled by an enable input.

Parameters:
- XPOS, 112: left edge of title rectangle, in pixels.
- YPOS, 50: top edge of title rectangle, in pixels.
- WIDTH, 800: rectangle width; also the row stride in the ROM address space.
- HEIGHT, 131: rectangle height.
- ROM_LAT, 1: clock cycles from rom_addr registered to rom_pixel valid.
- KEY_COLOR, 24'h00FF00: ROM value treated as transparent.
- FADE_FRAMES, 2: frames per alpha step.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  request title visible.
- hcount_in  in  11  horizontal pixel count.
- vcount_in  in  11  vertical line count.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- hblnk_in  in  1  horizontal blanking.
- vblnk_in  in  1  vertical blanking.
- rgb_in  in  24  background colour.
- rom_pixel  in  24  pixel data returned by the title ROM.
- rom_addr  out  20  title ROM address.
- hcount_out  out  11  delayed hcount.
- vcount_out  out  11  delayed vcount.
- hsync_out  out  1  delayed hsync.
- vsync_out  out  1  delayed vsync.
- hblnk_out  out  1  delayed hblnk.
- vblnk_out  out  1  delayed vblnk.
- rgb_out  out  24  composited colour.
- title_on  out  1  high only in state ON.

Behaviour:
- Reset (rst=0, async): all outputs 0; pipeline registers 0; state OFF; alpha 0; frame counter 0; vsync edge register 0.
- Stage A (1 cycle):
  - in_rect = (XPOS <= hcount_in < XPOS+WIDTH) && (YPOS <= vcount_in < YPOS+HEIGHT).
  - rom_addr <= in_rect ? (vcount_in-YPOS)*WIDTH + (hcount_in-XPOS) : 0, truncated to 20 bits.
  - Timing, rgb_in and in_rect are registered alongside.
- Delay line: timing, rgb and in_rect are delayed a further ROM_LAT cycles so they align with rom_pixel.
- Output stage (1 cycle): all *_out registered. Total latency input to output = ROM_LAT+2 cycles (3 at defaults), identical for every signal.
- Compositing:
  - Delayed hblnk or vblnk high -> rgb_out = 0.
  - Else !in_rect or rom_pixel == KEY_COLOR or alpha == 0 -> background.
  - Else per 8-bit channel: (rom*alpha + bg*(16-alpha)) >> 4, with alpha in 0..16 (5 bits).
  - Products are 13 bits and sums fit 13 bits; the result is truncated to 8 bits. alpha=16 yields rom exactly.
- Frame tick: one-cycle pulse on the rising edge of vsync_in (registered compare). The frame counter counts ticks 0..FADE_FRAMES-1; each wrap is a step.
- FSM:
  - OFF: alpha=0. enable=1 -> FADE_IN.
  - FADE_IN: on each step alpha+1. alpha reaches 16 -> ON. enable=0 -> FADE_OUT, keeping current alpha.
  - ON: alpha=16. enable=0 -> FADE_OUT.
  - FADE_OUT: on each step alpha-1. alpha reaches 0 -> OFF. enable=1 -> FADE_IN, keeping current alpha.
- State transitions happen on the cycle enable is sampled. The frame counter clears on every state change.
- alpha changes only on step cycles, so it is constant within a frame.
- Saturation: alpha never exceeds 16 or goes below 0, including when enable toggles and a step occur in the same cycle. In that case the transition takes priority and no step is applied.
- Reset mid-frame: outputs go to 0 immediately; the pipeline refills after ROM_LAT+2 cycles.

Optional Feature:
- Macro: TITLE_FADE_EN.
- Defined: fade FSM as above.
- Undefined: FADE_IN and FADE_OUT are removed and alpha jumps directly.
  - enable=1 -> ON (alpha=16) on the next clock.
  - enable=0 -> OFF (alpha=0) on the next clock.
  - Frame counter and vsync edge logic are not synthesized.
- Latency and compositing are unchanged in both builds.

Test Plan:
- Reset released, enable=0, hcount=200, vcount=60, rgb_in=24'h123456 -> rgb_out=24'h123456 after 3 cycles; rom_addr=10*800+88=8088 after 1 cycle; title_on=0.
- enable=1 held for 40 frames (TITLE_FADE_EN defined, FADE_FRAMES=2) -> alpha reaches 16 after 32 vsync rising edges; title_on=1. Pixel in rect with rom_pixel=24'hFF0000 yields rgb_out=24'hFF0000.
- alpha=8, rom_pixel=24'hFF0000, rgb_in=24'h0000FF -> rgb_out=24'h7F007F.
- In rect, rom_pixel=KEY_COLOR, alpha=16 -> rgb_out=rgb_in. Point outside rect (hcount=50) -> rom_addr=0, rgb_out=rgb_in.
- hblnk_in=1 in rect -> rgb_out=0 after 3 cycles. Delayed hsync, vsync and counts match the inputs shifted by exactly 3 cycles.
- enable dropped during FADE_IN at alpha=5 -> FADE_OUT; alpha 4,3,... reaching 0 after 10 frames -> OFF. Assert rst=0 mid-line -> all outputs 0 the same cycle.
